// File: rtl/alu_ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// with the EX/MEM result register folded in.
module alu_ex_stage #(
    parameter int NBITS = 32,
    parameter int ALUOP = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Valid,
    input  logic [ALUOP-1:0] i_ALUOp,
    input  logic [NBITS-1:0] i_A,
    input  logic [NBITS-1:0] i_B,
    input  logic             i_Flush,
    input  logic             i_StallIn,
    output logic [NBITS-1:0] o_Result,
    output logic             o_Zero,
    output logic             o_Valid,
    output logic             o_Invalid,
    output logic             o_Busy
);

    localparam int CW = $clog2(NBITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
    localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
    localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
    localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
    localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
    localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
    localparam logic [ALUOP-1:0] OP_MUL = ALUOP'(4'b1000);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] mcand;
    logic [NBITS-1:0] mplier;
    logic [NBITS-1:0] acc;

    logic [NBITS-1:0] alu_res;
    logic             legal;
    logic             is_mul;

    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (i_ALUOp)
            OP_AND: alu_res = i_A & i_B;
            OP_OR:  alu_res = i_A | i_B;
            OP_ADD: alu_res = i_A + i_B;
            OP_SUB: alu_res = i_A - i_B;
            OP_SLT: alu_res = {{(NBITS-1){1'b0}},
                               ($signed(i_A) < $signed(i_B))};
            OP_NOR: alu_res = ~(i_A | i_B);
            // illegal codes yield a zero result
            default: legal = 1'b0;
        endcase
    end

    assign is_mul = (i_ALUOp == OP_MUL);

    assign o_Busy = (state == S_MUL) |
                    ((state == S_IDLE) & i_Valid & is_mul & ~i_Flush);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            o_Result  <= '0;
            o_Zero    <= 1'b0;
            o_Valid   <= 1'b0;
            o_Invalid <= 1'b0;
        end else if (i_Flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            o_Result  <= '0;
            o_Zero    <= 1'b0;
            o_Valid   <= 1'b0;
            o_Invalid <= 1'b0;
        end else if (!i_StallIn) begin
            case (state)
                S_IDLE: begin
                    if (i_Valid && is_mul) begin
                        mcand     <= i_A;
                        mplier    <= i_B;
                        acc       <= '0;
                        cnt       <= '0;
                        o_Valid   <= 1'b0;
                        o_Invalid <= 1'b0;
                        state     <= S_MUL;
                    end else if (i_Valid) begin
                        o_Result  <= alu_res;
                        o_Zero    <= (alu_res == '0);
                        o_Valid   <= 1'b1;
                        o_Invalid <= ~legal;
                    end else begin
                        o_Valid   <= 1'b0;
                        o_Invalid <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NBITS - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    o_Result  <= acc;
                    o_Zero    <= (acc == '0);
                    o_Valid   <= 1'b1;
                    o_Invalid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: vector table for single-cycle ops,
// hand sequences for multiply, stall, flush and reset.
module tb_alu_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        zero;
    logic        ovalid;
    logic        inval;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_ex_stage #(.NBITS(32), .ALUOP(4)) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_Valid   (valid),
        .i_ALUOp   (op),
        .i_A       (a),
        .i_B       (b),
        .i_Flush   (flush),
        .i_StallIn (stall),
        .o_Result  (result),
        .o_Zero    (zero),
        .o_Valid   (ovalid),
        .o_Invalid (inval),
        .o_Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        inv;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb,
                           input logic [31:0] exp, input int st_at,
                           input int st_len, input string nm);
        int  n;
        bit  done;
        valid = 1'b1;
        op    = 4'b1000;
        a     = ma;
        b     = mb;
        #1;
        chk({nm, " busy_present"}, 32'(busy), 32'd1);
        n    = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (st_len > 0 && n == st_at) stall = 1'b1;
            if (st_len > 0 && n == st_at + st_len) stall = 1'b0;
            if (st_len > 0 && n == st_at + 2) begin
                chk({nm, " busy_stalled"}, 32'(busy), 32'd1);
                chk({nm, " valid_stalled"}, 32'(ovalid), 32'd0);
            end
            if (st_len == 0 && n == 32)
                chk({nm, " busy_E31"}, 32'(busy), 32'd1);
            if (st_len == 0 && n == 33) begin
                chk({nm, " busy_done"}, 32'(busy), 32'd0);
                chk({nm, " valid_done"}, 32'(ovalid), 32'd0);
            end
            if (ovalid) done = 1'b1;
        end
        valid = 1'b0;
        stall = 1'b0;
        chk({nm, " edges"}, 32'(n), 32'(34 + st_len));
        chk({nm, " result"}, result, exp);
        chk({nm, " zero"}, 32'(zero), 32'(exp == 32'd0));
        chk({nm, " invalid"}, 32'(inval), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, "add_wrap"};
        vecs[1] = '{4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_neg"};
        vecs[2] = '{4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, "slt_true"};
        vecs[3] = '{4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, "slt_false"};
        vecs[4] = '{4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, "nor_zero"};
        vecs[5] = '{4'b1111, 32'h12345678, 32'h1, 32'd0, 1'b1, 1'b1, "illegal_f"};
        vecs[6] = '{4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000,
                    1'b0, 1'b0, "and"};
        vecs[7] = '{4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01,
                    1'b0, 1'b0, "or"};
        vecs[8] = '{4'b1110, 32'h5, 32'h3, 32'd0, 1'b1, 1'b1, "illegal_e"};
        vecs[9] = '{4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, "add"};

        rst_n = 1'b0;
        valid = 1'b0;
        op    = 4'b0;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst result", result, 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst valid", 32'(ovalid), 32'd0);
        chk("rst invalid", 32'(inval), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        tick();
        chk("idle valid", 32'(ovalid), 32'd0);

        // back-to-back single-cycle ops, one result per edge
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1;
            op    = vecs[i].op;
            a     = vecs[i].a;
            b     = vecs[i].b;
            tick();
            chk({vecs[i].name, " result"}, result, vecs[i].res);
            chk({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].zero));
            chk({vecs[i].name, " valid"}, 32'(ovalid), 32'd1);
            chk({vecs[i].name, " invalid"}, 32'(inval), 32'(vecs[i].inv));
        end

        valid = 1'b0;
        tick();
        chk("bubble valid", 32'(ovalid), 32'd0);
        chk("bubble held", result, 32'd123);

        run_mul(32'd7, 32'd6, 32'd42, 0, 0, "mul7x6");
        tick();
        chk("mul bubble", 32'(ovalid), 32'd0);
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 0, "mul_big");
        tick();
        run_mul(32'd3, 32'd3, 32'd9, 6, 5, "mul_stall");
        tick();

        // flush at E10 of a multiply
        valid = 1'b1;
        op    = 4'b1000;
        a     = 32'd11;
        b     = 32'd13;
        for (int e = 0; e < 10; e++) tick();
        chk("pre_flush busy", 32'(busy), 32'd1);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        chk("flush valid", 32'(ovalid), 32'd0);
        chk("flush result", result, 32'd0);
        op = 4'b0010;
        a  = 32'd2;
        b  = 32'd2;
        #1;
        chk("flush idle busy", 32'(busy), 32'd0);
        tick();
        chk("post_flush add", result, 32'd4);
        chk("post_flush valid", 32'(ovalid), 32'd1);

        // reset in the middle of a multiply
        op = 4'b1000;
        a  = 32'd5;
        b  = 32'd5;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst valid", 32'(ovalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
